// File: rtl/serial_capture_fifo.sv
// serial_capture_fifo: captures processor serial bytes into a FIFO, popped by a debounced active-low key.
// Define SERCAP_FAST_POP_EN to bypass the debounce counter (debounced level = second sync flop).
module serial_capture_fifo #(
   parameter int DEPTH = 16,
   parameter int ADDR_W = 4,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        serial_in,
   input  logic              serial_wren,
   output logic              serial_ready_out,
   input  logic              pop_key,
   input  logic              clear,
   output logic [7:0]        head_data,
   output logic              head_valid,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic [31:0]       last_word
);
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
   logic [7:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic sync0, sync1, db, db_d;
   logic full, empty, push_ok, pop_ok;
   always_comb begin
      full = count == FULL;
      empty = count == '0;
      push_ok = serial_wren && !full;
      pop_ok = db_d && !db && !empty;
      serial_ready_out = !full;
      head_valid = !empty;
      head_data = empty ? 8'h00 : mem[rd_ptr];
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
         last_word <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
         last_word <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            last_word <= {last_word[23:0], serial_in};
         end
         if (serial_wren && full)
            overflow <= 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + ADDR_W'(1);
         count <= count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
      end
   end
   always_ff @(posedge clock)
      if (!reset && !clear && push_ok)
         mem[wr_ptr] <= serial_in;
`ifdef SERCAP_FAST_POP_EN
   always_comb db = sync1;
   always_ff @(posedge clock) begin
      if (reset) begin
         sync0 <= 1'b1;
         sync1 <= 1'b1;
         db_d <= 1'b1;
      end else begin
         sync0 <= pop_key;
         sync1 <= sync0;
         db_d <= sync1;
      end
   end
`else
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [CNT_W-1:0] db_cnt;
   // the pop pulse is db_d & ~db, so it lands the cycle after the debounced fall
   always_ff @(posedge clock) begin
      if (reset) begin
         sync0 <= 1'b1;
         sync1 <= 1'b1;
         db <= 1'b1;
         db_d <= 1'b1;
         db_cnt <= '0;
      end else begin
         sync0 <= pop_key;
         sync1 <= sync0;
         db_d <= db;
         if (sync1 == db)
            db_cnt <= '0;
         else if (db_cnt == CNT_MAX) begin
            db <= sync1;
            db_cnt <= '0;
         end else
            db_cnt <= db_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_serial_capture_fifo.sv
// tb_serial_capture_fifo: randomized/directed bench against a queue-based reference model.
module tb_serial_capture_fifo;
   localparam int DEPTH = 16;
`ifdef SERCAP_FAST_POP_EN
   localparam bit FAST = 1'b1;
   localparam int POP_LAT = 3;
`else
   localparam bit FAST = 1'b0;
   localparam int POP_LAT = 7;
`endif
   logic clock = 1'b0, reset = 1'b1, serial_wren = 1'b0, pop_key = 1'b1, clear = 1'b0;
   logic [7:0] serial_in = 8'h00;
   logic serial_ready_out, head_valid, overflow;
   logic [7:0] head_data;
   logic [4:0] count;
   logic [31:0] last_word;
   int checks = 0, errors = 0, pop_due = 0, pushes = 0;
   logic [7:0] q[$];
   logic m_ovf = 1'b0;
   logic [31:0] m_lw = 32'h0;

   always #5 clock = ~clock;

   serial_capture_fifo #(.DEPTH(16), .ADDR_W(4), .DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .serial_in(serial_in), .serial_wren(serial_wren),
      .serial_ready_out(serial_ready_out), .pop_key(pop_key), .clear(clear),
      .head_data(head_data), .head_valid(head_valid), .count(count),
      .overflow(overflow), .last_word(last_word)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; the model applies the spec's push/pop/clear rules to a queue.
   task automatic step(input logic wr, input logic [7:0] d, input logic clr = 1'b0);
      bit pop_now, full, empty;
      pop_now = 1'b0;
      @(negedge clock);
      serial_wren = wr;
      serial_in = d;
      clear = clr;
      @(posedge clock);
      if (pop_due > 0) begin
         pop_due--;
         pop_now = (pop_due == 0);
      end
      full = q.size() == DEPTH;
      empty = q.size() == 0;
      if (clr) begin
         q.delete();
         m_ovf = 1'b0;
         m_lw = 32'h0;
      end else begin
         if (pop_now && !empty) void'(q.pop_front());
         if (wr && full) m_ovf = 1'b1;
         else if (wr) begin
            q.push_back(d);
            m_lw = {m_lw[23:0], d};
            pushes++;
         end
      end
      #1;
      chk("count", 32'(count), 32'(q.size()));
      chk("head_valid", 32'(head_valid), 32'(q.size() != 0));
      chk("head_data", 32'(head_data), 32'(q.size() != 0 ? q[0] : 8'h00));
      chk("ready", 32'(serial_ready_out), 32'(q.size() != DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("last_word", last_word, m_lw);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00);
   endtask

   task automatic press_release(input bit rnd);
      pop_key = 1'b0;
      pop_due = POP_LAT;
      repeat (10) step(rnd ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
      pop_key = 1'b1;
      repeat (10) step(rnd ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
   endtask

   initial begin
      serial_wren = 1'b1;
      serial_in = 8'hAA;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_head_valid", 32'(head_valid), 0);
      chk("rst_ready", 32'(serial_ready_out), 1);
      chk("rst_last_word", last_word, 0);
      chk("rst_overflow", 32'(overflow), 0);
      @(negedge clock);
      reset = 1'b0;
      serial_wren = 1'b0;
      idle(2);
      step(1'b1, 8'h41);
      step(1'b1, 8'h42);
      step(1'b1, 8'h43);
      chk("p3_count", 32'(count), 3);
      chk("p3_head", 32'(head_data), 32'h41);
      chk("p3_last_word", last_word, 32'h00414243);
      pop_key = 1'b0;
      pop_due = POP_LAT;
      idle(7);
      chk("pop_head", 32'(head_data), 32'h42);
      chk("pop_count", 32'(count), 2);
      idle(50);
      chk("hold_count", 32'(count), 2);
      pop_key = 1'b1;
      idle(10);
      press_release(1'b0);
      press_release(1'b0);
      chk("drained", 32'(count), 0);
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
      chk("full_ready", 32'(serial_ready_out), 0);
      chk("full_count", 32'(count), 16);
      step(1'b1, 8'hFF);
      chk("drop_overflow", 32'(overflow), 1);
      chk("drop_last_word", last_word, 32'h0C0D0E0F);
      pop_key = 1'b0;
      pop_due = POP_LAT;
      idle(POP_LAT);
      chk("pop_full_ready", 32'(serial_ready_out), 1);
      chk("pop_full_head", 32'(head_data), 32'h01);
      pop_key = 1'b1;
      idle(10);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom));
      pop_key = 1'b0;
      pop_due = POP_LAT;
      idle(POP_LAT - 1);
      step(1'b1, 8'hEE);
      chk("sim_full_count", 32'(count), 15);
      chk("sim_full_overflow", 32'(overflow), 1);
      pop_key = 1'b1;
      idle(10);
      step(1'b0, 8'h00, 1'b1);
      pop_key = 1'b0;
      pop_due = POP_LAT;
      idle(POP_LAT - 1);
      step(1'b1, 8'h5A);
      chk("sim_empty_count", 32'(count), 1);
      chk("sim_empty_head", 32'(head_data), 32'h5A);
      pop_key = 1'b1;
      idle(10);
      pop_key = 1'b0;
      if (FAST) pop_due = POP_LAT;
      idle(3);
      pop_key = 1'b1;
      idle(10);
      chk("glitch_count", 32'(count), FAST ? 0 : 1);
      step(1'b0, 8'h00, 1'b1);
      pushes = 0;
      for (int i = 0; i < 60; i++) begin
         if (q.size() > 8 || (q.size() != 0 && $urandom_range(0, 1) == 0))
            press_release(1'b0);
         else
            repeat ($urandom_range(1, 3)) step(1'b1, 8'($urandom));
         chk("count_le_depth", 32'(count <= 5'd16), 1);
      end
      chk("wrap_pushes_ge_32", 32'(pushes >= 32), 1);
      press_release(1'b1);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom));
      repeat (11) press_release(1'b0);
      chk("pre_clear_count", 32'(count), 5);
      chk("pre_clear_overflow", 32'(overflow), 1);
      step(1'b0, 8'h00, 1'b1);
      chk("clear_count", 32'(count), 0);
      chk("clear_overflow", 32'(overflow), 0);
      chk("clear_head", 32'(head_data), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
